led_shift_receiver: RTL and testbench
=====================================

Name: led_shift_receiver

Overview:
Receiving end of the LED-driver serial interface, i.e. the load/sclk/latch/oe_n bus produced by the panel sequencer. It samples the serial data line and the control strobes, shifts in one WIDTH-bit frame per load…latch sequence, and presents the latched word with a valid pulse. It is used on slave panel boards and as an in-FPGA loopback checker for the sequencer.

Parameters:
WIDTH, 16, number of data bits per frame (sclk rising edges between load and latch)
CNT_W, 16, width of the good-frame and error-frame counters

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
serial_data  input  1  serial data line, MSB first
load  input  1  frame-start strobe
sclk  input  1  shift clock; data is sampled on its rising edge
latch_enable  input  1  latch strobe; rising edge ends the frame
output_enable_n  input  1  active-low display enable
latched_data  output  WIDTH  last good frame
data_valid  output  1  one-cycle pulse when latched_data updates
frame_error  output  1  one-cycle pulse on a bad frame
display_enable  output  1  registered, synchronized ~output_enable_n
busy  output  1  high while in SHIFT
frame_count  output  CNT_W  good frames since reset, wraps
error_count  output  CNT_W  bad frames since reset, saturates at all-ones

Behaviour:
- Interface: one clock `clk`. Reset `reset` is synchronous and active-high.
- Inputs pass through a 2-FF synchronizer, then a third delay stage for edge detection. Edges are detected on stage2=1 and stage3=0.
- Synchronizer reset values: output_enable_n chain resets to 1; all other chains reset to 0.
- Any input level held for ≥1 clk cycle must be detected. The driver is clocked by clk or slower.
- Reset values: latched_data=0, data_valid=0, frame_error=0, display_enable=0, busy=0, frame_count=0, error_count=0, shift_reg=0, bit_cnt=0, state=IDLE.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: sclk edges are ignored. A load edge clears shift_reg and bit_cnt and moves to SHIFT. A latch edge gives an error, stays in IDLE.
  - SHIFT: each sclk edge does shift_reg <= {shift_reg[WIDTH-2:0], serial_data_sync}. bit_cnt increments and saturates at WIDTH+1. The serial_data sample is taken from the same synchronizer stage as the sclk edge.
  - SHIFT, on a latch edge with bit_cnt==WIDTH: latched_data <= shift_reg, data_valid pulse, frame_count+1, go to DONE.
  - SHIFT, on a latch edge with bit_cnt≠WIDTH (underrun or overrun): frame_error pulse, error_count+1, latched_data unchanged, go to IDLE.
  - SHIFT, on a load edge: restart the frame by clearing bit_cnt and shift_reg. No error is raised.
  - DONE: sclk edges are ignored. A load edge moves to SHIFT as from IDLE. A second latch edge is ignored (driver holds latch several cycles, then re-strobes).
- Simultaneous events in one cycle, in priority order:
  1. load edge: clear.
  2. sclk edge: shift, counting as bit 1 if load was also present.
  3. latch edge: the bit_cnt check uses the post-shift count, and the latched value includes that shift.
- Latency: latch_enable first sampled high at clk edge k gives data_valid high during the cycle after edge k+3. display_enable follows output_enable_n with the same 3-edge latency.
- data_valid and frame_error are never high together. Each is exactly 1 cycle wide.
- busy = (state==SHIFT), registered.
- Reset asserted mid-frame: everything returns to reset values on the next clk edge. A frame in progress is discarded and no error is counted.

Test Plan:
- Frame with load, 16 sclk pulses shifting 0xA5C3 MSB first, then latch → latched_data=0xA5C3, data_valid high exactly 1 cycle, frame_count=1, frame_error never high.
- Frame with only 15 sclk pulses then latch → frame_error 1 cycle, error_count=1, latched_data keeps the previous 0xA5C3, state returns to IDLE (busy=0).
- Frame with 17 sclk pulses then latch → frame_error, error_count increments, no data_valid. A following correct frame of 0x0001 gives latched_data=0x0001.
- Latch with no preceding load, and sclk pulses while in IDLE → frame_error once, shift_reg unaffected. Latch held 4 cycles after a good frame → only one data_valid.
- output_enable_n driven 1→0→1 with 5-cycle low → display_enable low-high-low, high for 5 cycles, transitions 3 edges after the input.
- reset asserted after 8 of 16 bits, then a full frame of 0xFFFF → all outputs 0 the cycle after reset, then latched_data=0xFFFF, frame_count=1, error_count=0.

Source files
------------

// File: rtl/led_shift_if.sv
// LED-driver serial bus between the panel sequencer (master) and a receiver (slave).
// Driver-side strobes: serial_data, load, sclk, latch_enable, output_enable_n.
// Receiver-side results: latched_data, data_valid, frame_error, display_enable, busy,
// frame_count, error_count.
interface led_shift_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
);
  logic             serial_data;
  logic             load;
  logic             sclk;
  logic             latch_enable;
  logic             output_enable_n;
  logic [WIDTH-1:0] latched_data;
  logic             data_valid;
  logic             frame_error;
  logic             display_enable;
  logic             busy;
  logic [CNT_W-1:0] frame_count;
  logic [CNT_W-1:0] error_count;

  modport master (
    output serial_data, load, sclk, latch_enable, output_enable_n,
    input  latched_data, data_valid, frame_error, display_enable, busy,
           frame_count, error_count
  );

  modport slave (
    input  serial_data, load, sclk, latch_enable, output_enable_n,
    output latched_data, data_valid, frame_error, display_enable, busy,
           frame_count, error_count
  );
endinterface

// File: rtl/led_shift_receiver.sv
// Receiving end of the LED-driver serial bus. Synchronizes the bus strobes, shifts one
// WIDTH-bit frame (MSB first) per load..latch sequence and presents the latched word.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - led_shift_if slave: serial inputs in, latched word / pulses / counters out
module led_shift_receiver #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input logic        clk,
  input logic        reset,
  led_shift_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 2);
  localparam logic [CntW-1:0] BitsFull = CntW'(WIDTH);
  localparam logic [CntW-1:0] BitsMax  = CntW'(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  // Bit 0 = first synchronizer flop, bit 1 = second, bit 2 = edge-detect delay.
  logic [1:0] data_sync;
  logic [2:0] load_sync, sclk_sync, latch_sync, oe_sync;

  // Registered edge flags, with the data sample taken from the same stage as sclk.
  logic load_edge_q, sclk_edge_q, latch_edge_q, data_q;

  state_e           state_q;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             framing;

  logic [WIDTH-1:0] latched_q;
  logic             valid_q, error_q, disp_q, busy_q;
  logic [CNT_W-1:0] fcnt_q, ecnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_sync    <= '0;
      load_sync    <= '0;
      sclk_sync    <= '0;
      latch_sync   <= '0;
      oe_sync      <= '1;
      load_edge_q  <= 1'b0;
      sclk_edge_q  <= 1'b0;
      latch_edge_q <= 1'b0;
      data_q       <= 1'b0;
    end else begin
      data_sync    <= {data_sync[0], bus.serial_data};
      load_sync    <= {load_sync[1:0], bus.load};
      sclk_sync    <= {sclk_sync[1:0], bus.sclk};
      latch_sync   <= {latch_sync[1:0], bus.latch_enable};
      oe_sync      <= {oe_sync[1:0], bus.output_enable_n};
      load_edge_q  <= load_sync[1] & ~load_sync[2];
      sclk_edge_q  <= sclk_sync[1] & ~sclk_sync[2];
      latch_edge_q <= latch_sync[1] & ~latch_sync[2];
      data_q       <= data_sync[1];
    end
  end

  // Same-cycle priority: load clears first, then sclk shifts (as bit 1 after a load);
  // the latch check below sees the post-shift count and value.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    framing = (state_q == StShift);
    if (load_edge_q) begin
      shift_d = '0;
      cnt_d   = '0;
      framing = 1'b1;
    end
    if (sclk_edge_q && framing) begin
      shift_d = {shift_d[WIDTH-2:0], data_q};
      if (cnt_d != BitsMax) cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      cnt_q     <= '0;
      latched_q <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      disp_q    <= 1'b0;
      busy_q    <= 1'b0;
      fcnt_q    <= '0;
      ecnt_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      disp_q  <= ~oe_sync[2];
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      if (latch_edge_q && framing) begin
        busy_q <= 1'b0;
        if (cnt_d == BitsFull) begin
          latched_q <= shift_d;
          valid_q   <= 1'b1;
          fcnt_q    <= fcnt_q + 1'b1;
          state_q   <= StDone;
        end else begin
          error_q <= 1'b1;
          if (ecnt_q != '1) ecnt_q <= ecnt_q + 1'b1;
          state_q <= StIdle;
        end
      end else if (latch_edge_q && state_q == StIdle) begin
        // Latch with no frame open; a repeated latch in StDone is silently ignored.
        error_q <= 1'b1;
        if (ecnt_q != '1) ecnt_q <= ecnt_q + 1'b1;
      end else if (framing) begin
        state_q <= StShift;
        busy_q  <= 1'b1;
      end
    end
  end

  assign bus.latched_data   = latched_q;
  assign bus.data_valid     = valid_q;
  assign bus.frame_error    = error_q;
  assign bus.display_enable = disp_q;
  assign bus.busy           = busy_q;
  assign bus.frame_count    = fcnt_q;
  assign bus.error_count    = ecnt_q;

endmodule

// File: tb/tb_led_shift_receiver.sv
// Scoreboard bench for led_shift_receiver: driver tasks update a frame-level model and
// queue expected pulses; a negedge monitor pops and compares whenever a pulse appears.
module tb_led_shift_receiver;
  localparam int W  = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  led_shift_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  led_shift_receiver #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    bit           is_err;
    logic [W-1:0] data;
    int           cyc;
    int           fcnt;
    int           ecnt;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Frame-level model: 0 = no frame, 1 = frame open, 2 = frame delivered.
  int           m_mode = 0;
  bit           m_bits[$];
  logic [W-1:0] m_latched = '0;
  int           m_fcnt = 0;
  int           m_ecnt = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!reset && (bus.data_valid || bus.frame_error)) begin
      check("valid_error_exclusive", 64'(bus.data_valid & bus.frame_error), 64'd0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: valid=%b error=%b, nothing expected (cycle %0d)",
                 bus.data_valid, bus.frame_error, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_kind_error", 64'(bus.frame_error), 64'(e.is_err));
        check("pulse_latency", 64'(cyc), 64'(e.cyc));
        if (!e.is_err) check("latched_data", 64'(bus.latched_data), 64'(e.data));
        check("frame_count", 64'(bus.frame_count), 64'(e.fcnt));
        check("error_count", 64'(bus.error_count), 64'(e.ecnt));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load();
    m_mode = 1;
    m_bits.delete();
    bus.load = 1'b1;
    tick(2);
    bus.load = 1'b0;
    tick(2);
  endtask

  task automatic do_bit(input bit b);
    if (m_mode == 1) m_bits.push_back(b);
    bus.serial_data = b;
    tick(1);
    bus.sclk = 1'b1;
    tick(1);
    bus.sclk = 1'b0;
    tick(1);
  endtask

  task automatic do_latch(input int hold);
    exp_t e;
    bit   push = 1'b0;
    if (m_mode == 1) begin
      push = 1'b1;
      if (m_bits.size() == W) begin
        m_latched = '0;
        foreach (m_bits[i]) m_latched = {m_latched[W-2:0], m_bits[i]};
        m_fcnt++;
        e.is_err = 1'b0;
        m_mode = 2;
      end else begin
        m_ecnt++;
        e.is_err = 1'b1;
        m_mode = 0;
      end
    end else if (m_mode == 0) begin
      push = 1'b1;
      m_ecnt++;
      e.is_err = 1'b1;
    end
    if (push) begin
      e.data = m_latched;
      e.cyc  = cyc + 4;
      e.fcnt = m_fcnt;
      e.ecnt = m_ecnt;
      sb.push_back(e);
    end
    bus.latch_enable = 1'b1;
    tick(hold);
    bus.latch_enable = 1'b0;
    tick(4);
  endtask

  task automatic send_frame(input logic [W-1:0] data, input int nb, input bit ld,
                            input int hold);
    if (ld) do_load();
    for (int i = 0; i < nb; i++) begin
      if (i < W) do_bit(data[W-1-i]);
      else do_bit(1'($urandom));
    end
    do_latch(hold);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    m_mode = 0;
    m_bits.delete();
    m_latched = '0;
    m_fcnt = 0;
    m_ecnt = 0;
    sb.delete();
    check("rst_latched_data", 64'(bus.latched_data), 64'd0);
    check("rst_data_valid", 64'(bus.data_valid), 64'd0);
    check("rst_frame_error", 64'(bus.frame_error), 64'd0);
    check("rst_display_enable", 64'(bus.display_enable), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_frame_count", 64'(bus.frame_count), 64'd0);
    check("rst_error_count", 64'(bus.error_count), 64'd0);
    reset = 1'b0;
  endtask

  initial begin
    int c0;
    int highs;
    bus.serial_data     = 1'b0;
    bus.load            = 1'b0;
    bus.sclk            = 1'b0;
    bus.latch_enable    = 1'b0;
    bus.output_enable_n = 1'b1;
    reset = 1'b1;
    tick(3);
    do_reset();
    tick(2);

    // Good frame, latch held 4 cycles: one data_valid only.
    send_frame(16'hA5C3, W, 1'b1, 4);
    tick(2);
    check("good_latched", 64'(bus.latched_data), 64'hA5C3);
    check("good_fcnt", 64'(bus.frame_count), 64'd1);

    // Underrun.
    do_load();
    for (int i = 0; i < W - 1; i++) do_bit(1'($urandom));
    check("busy_in_frame", 64'(bus.busy), 64'd1);
    do_latch(1);
    check("underrun_keeps_data", 64'(bus.latched_data), 64'hA5C3);
    check("underrun_busy", 64'(bus.busy), 64'd0);
    check("underrun_ecnt", 64'(bus.error_count), 64'd1);

    // Overrun, then a good 0x0001 frame.
    send_frame(16'h1234, W + 1, 1'b1, 2);
    send_frame(16'h0001, W, 1'b1, 1);
    check("after_overrun_data", 64'(bus.latched_data), 64'h0001);

    // Short frame to get back to idle, then sclk pulses in idle and a lone latch.
    send_frame(16'hFFFF, 3, 1'b1, 1);
    send_frame(16'hFFFF, 5, 1'b0, 2);
    send_frame(16'hBEEF, W, 1'b1, 1);

    // Display enable: 5-cycle low on output_enable_n, 3-edge latency.
    c0 = cyc;
    highs = 0;
    bus.output_enable_n = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick(1);
      check("display_enable", 64'(bus.display_enable),
            64'((cyc >= c0 + 4) && (cyc <= c0 + 8)));
      if (bus.display_enable) highs++;
      if (cyc == c0 + 5) bus.output_enable_n = 1'b1;
    end
    check("display_high_cycles", 64'(highs), 64'd5);

    // Reset after 8 of 16 bits, then a full 0xFFFF frame.
    do_load();
    for (int i = 0; i < 8; i++) do_bit(1'b1);
    do_reset();
    tick(2);
    send_frame(16'hFFFF, W, 1'b1, 1);
    tick(2);
    check("post_reset_data", 64'(bus.latched_data), 64'hFFFF);
    check("post_reset_fcnt", 64'(bus.frame_count), 64'd1);
    check("post_reset_ecnt", 64'(bus.error_count), 64'd0);

    // Randomized frames.
    for (int n = 0; n < 40; n++) begin
      int r;
      int nb;
      r = int'($urandom_range(0, 5));
      case (r)
        0:       nb = W - 1;
        1:       nb = W + 1;
        2:       nb = int'($urandom_range(0, 3));
        default: nb = W;
      endcase
      send_frame(16'($urandom), nb, ($urandom_range(0, 7) != 0),
                 int'($urandom_range(1, 4)));
    end

    tick(10);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    check("final_fcnt", 64'(bus.frame_count), 64'(m_fcnt));
    check("final_ecnt", 64'(bus.error_count), 64'(m_ecnt));
    check("final_latched", 64'(bus.latched_data), 64'(m_latched));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
